// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the alu_seq command sequencer:
//   - FSM state encoding
//   - bit offsets and widths of the fields in the 19-bit command word
//   - ALU opcode and status constants
//   - helper that flags commands the ALU cannot execute
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  // Command word: {opcode[3:0], swapop, swapvl, cin, srca, srcb, dsta, dstb}
  localparam int CMD_W      = 19;
  localparam int OPC_LSB    = 15;
  localparam int OPC_W      = 4;
  localparam int SWAPOP_BIT = 14;
  localparam int SWAPVL_BIT = 13;
  localparam int CIN_BIT    = 12;
  localparam int SRCA_LSB   = 9;
  localparam int SRCB_LSB   = 6;
  localparam int DSTA_LSB   = 3;
  localparam int DSTB_LSB   = 0;
  localparam int REG_W      = 3;

  // Low two opcode bits select the ALU operation
  localparam logic [1:0] OP_FA      = 2'b00;
  localparam logic [1:0] OP_MUL     = 2'b01;
  localparam logic [1:0] OP_INV     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  // ALU status encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // A non-swap command with opcode[1:0]=11 has no ALU implementation
  function automatic logic cmd_illegal(input logic [CMD_W-1:0] c);
    return (!c[SWAPOP_BIT]) && (c[OPC_LSB +: 2] == OP_ILLEGAL);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile
// NREG x WID operand register file for the ALU sequencer.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset (clears all entries)
//   wba_en/addr/data         write-back port A (ALU result)
//   wbb_en/addr/data         write-back port B (ALU swap result, wins over port A)
//   wr_en/addr/data          host write port, dropped when it collides with a write-back
//   ra_addr/ra_data          combinational operand read port A
//   rb_addr/rb_data          combinational operand read port B
//   rd_addr/rd_data          registered host read port (returns pre-write contents)
module alu_seq_regfile #(
  parameter int WID  = 256,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wba_en,
  input  logic [AW-1:0]  wba_addr,
  input  logic [WID-1:0] wba_data,
  input  logic           wbb_en,
  input  logic [AW-1:0]  wbb_addr,
  input  logic [WID-1:0] wbb_data,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [WID-1:0] wr_data,
  input  logic [AW-1:0]  ra_addr,
  output logic [WID-1:0] ra_data,
  input  logic [AW-1:0]  rb_addr,
  output logic [WID-1:0] rb_data,
  input  logic [AW-1:0]  rd_addr,
  output logic [WID-1:0] rd_data
);

  logic [WID-1:0] mem [NREG];
  logic           hostOk;

  // Host write survives only if no write-back targets the same entry this cycle
  assign hostOk = wr_en
                  && !(wba_en && (wba_addr == wr_addr))
                  && !(wbb_en && (wbb_addr == wr_addr));

  // Storage and registered host read; port B is written last so the swap
  // result wins when both write-back ports hit the same entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (hostOk) mem[wr_addr]  <= wr_data;
      if (wba_en) mem[wba_addr] <= wba_data;
      if (wbb_en) mem[wbb_addr] <= wbb_data;
    end
  end

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Command sequencer and operand register file feeding the modular ALU wrapper.
// Accepts one micro-op at a time over cmd_vld/cmd_rdy, starts the ALU with a
// one-cycle alu_en pulse, waits for alu_vld and writes the result(s) back.
// Optional build macro ALU_SEQ_TIMEOUT_EN: bounds the wait for alu_vld to TOUT
// cycles, after which err is set, done pulses and the write-back is skipped.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data          host register write
//   rd_addr/rd_data                host register read (1-cycle latency)
//   cmd_vld/cmd_rdy/cmd            command handshake and 19-bit command word
//   alu_en, alu_opcode, alu_swapop,
//   alu_swapvl, alu_c, alu_a, alu_b ALU start pulse, controls and operands
//   alu_r, alu_rswap, alu_vld,
//   alu_status                     ALU results, result valid and status
//   busy, done, err                FSM active, retire pulse, sticky error
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WID  = 256,
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int TOUT = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WID-1:0]   wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WID-1:0]   rd_data,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [CMD_W-1:0] cmd,
  output logic             alu_en,
  output logic [OPC_W-1:0] alu_opcode,
  output logic             alu_swapop,
  output logic             alu_swapvl,
  output logic             alu_c,
  output logic [WID-1:0]   alu_a,
  output logic [WID-1:0]   alu_b,
  input  logic [WID-1:0]   alu_r,
  input  logic [WID-1:0]   alu_rswap,
  input  logic             alu_vld,
  input  logic [1:0]       alu_status,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state;
  logic [CMD_W-1:0] cmdq;
  logic             wbaEn;
  logic             wbbEn;
  logic             timeout;

  assign cmd_rdy    = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign alu_opcode = cmdq[OPC_LSB +: OPC_W];
  assign alu_swapop = cmdq[SWAPOP_BIT];
  assign alu_swapvl = cmdq[SWAPVL_BIT];
  assign alu_c      = cmdq[CIN_BIT];

  // Results are written straight from the ALU on the edge that samples alu_vld,
  // so the destination is already visible during the WB cycle
  assign wbaEn = (state == S_WAIT) && alu_vld;
  assign wbbEn = wbaEn && cmdq[SWAPOP_BIT];

  alu_seq_regfile #(
    .WID  (WID),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wba_en   (wbaEn),
    .wba_addr (AW'(cmdq[DSTA_LSB +: REG_W])),
    .wba_data (alu_r),
    .wbb_en   (wbbEn),
    .wbb_addr (AW'(cmdq[DSTB_LSB +: REG_W])),
    .wbb_data (alu_rswap),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ra_addr  (AW'(cmdq[SRCA_LSB +: REG_W])),
    .ra_data  (alu_a),
    .rb_addr  (AW'(cmdq[SRCB_LSB +: REG_W])),
    .rb_data  (alu_b),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TOUT + 1);
  logic [TW-1:0] waitCnt;

  // Counts WAIT cycles without alu_vld; restarts whenever the FSM leaves WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt <= '0;
    end else if (state != S_WAIT) begin
      waitCnt <= '0;
    end else if (!alu_vld) begin
      waitCnt <= waitCnt + TW'(1);
    end
  end

  assign timeout = (waitCnt == TW'(TOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // Main FSM. alu_en is raised on the edge where the ALU was seen idle, so the
  // pulse lands in the ISSUE cycle and the FSM moves to WAIT right after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cmdq   <= '0;
      alu_en <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      alu_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_vld) begin
            cmdq <= cmd;
            if (cmd_illegal(cmd)) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              err    <= 1'b0;
              state  <= S_ISSUE;
              alu_en <= (alu_status == ST_IDLE);
            end
          end
        end
        S_ISSUE: begin
          if (alu_en) begin
            state <= S_WAIT;
          end else if (alu_status == ST_IDLE) begin
            alu_en <= 1'b1;
          end
        end
        S_WAIT: begin
          if (alu_vld) begin
            state <= S_WB;
            done  <= 1'b1;
          end else if (timeout) begin
            state <= S_IDLE;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        S_WB: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
// Directed testbench for alu_seq. A small hand-driven ALU model answers each
// issued command; expected register contents are hand-computed constants.
module tb_alu_seq;

  localparam int WID = 256;

  logic           clk;
  logic           rst;
  logic           wr_en;
  logic [2:0]     wr_addr;
  logic [WID-1:0] wr_data;
  logic [2:0]     rd_addr;
  logic [WID-1:0] rd_data;
  logic           cmd_vld;
  logic           cmd_rdy;
  logic [18:0]    cmd;
  logic           alu_en;
  logic [3:0]     alu_opcode;
  logic           alu_swapop;
  logic           alu_swapvl;
  logic           alu_c;
  logic [WID-1:0] alu_a;
  logic [WID-1:0] alu_b;
  logic [WID-1:0] alu_r;
  logic [WID-1:0] alu_rswap;
  logic           alu_vld;
  logic [1:0]     alu_status;
  logic           busy;
  logic           done;
  logic           err;

  int testsRun;
  int testsFailed;
  int enCount;
  int doneCount;

  localparam logic [WID-1:0] VAL_A  = {4{64'hA5A5_5A5A_0123_4567}};
  localparam logic [WID-1:0] VAL_B  = {4{64'h0F0F_F0F0_89AB_CDEF}};
  localparam logic [WID-1:0] VAL_X1 = {8{32'h1111_2222}};
  localparam logic [WID-1:0] VAL_X2 = {8{32'h3333_4444}};
  localparam logic [WID-1:0] VAL_W1 = {64'hFEED_0000_0000_0001, 192'd77};
  localparam logic [WID-1:0] VAL_W2 = {64'h8000_0000_0000_0000, 192'd99};
  localparam logic [WID-1:0] VAL_W3 = {128'd5, 128'hC0DE};
  localparam logic [WID-1:0] VAL_H5 = {4{64'h5555_6666_7777_8888}};
  localparam logic [WID-1:0] VAL_JK = {4{64'hDEAD_BEEF_DEAD_BEEF}};
  localparam logic [WID-1:0] VAL_S5 = {2{128'h0BAD_F00D_1234_5678_9ABC_DEF0_1357_2468}};
  localparam logic [WID-1:0] VAL_6  = {4{64'h6666_0000_6666_0000}};
  localparam logic [WID-1:0] VAL_7  = {4{64'h7777_1111_7777_1111}};

  alu_seq #(
    .WID  (WID),
    .NREG (8),
    .AW   (3),
    .TOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cmd_vld    (cmd_vld),
    .cmd_rdy    (cmd_rdy),
    .cmd        (cmd),
    .alu_en     (alu_en),
    .alu_opcode (alu_opcode),
    .alu_swapop (alu_swapop),
    .alu_swapvl (alu_swapvl),
    .alu_c      (alu_c),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_r      (alu_r),
    .alu_rswap  (alu_rswap),
    .alu_vld    (alu_vld),
    .alu_status (alu_status),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: at posedge the DUT outputs still hold the previous cycle's value
  always @(posedge clk) begin
    if (alu_en === 1'b1) enCount++;
    if (done === 1'b1) doneCount++;
  end

  function automatic logic [18:0] mkCmd(input logic [3:0] opc, input logic sop, input logic svl,
                                        input logic ci, input logic [2:0] sa, input logic [2:0] sb,
                                        input logic [2:0] da, input logic [2:0] db);
    return {opc, sop, svl, ci, sa, sb, da, db};
  endfunction

  task automatic hostWrite(input logic [2:0] addr, input logic [WID-1:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic hostRead(input logic [2:0] addr, output logic [WID-1:0] data);
    rd_addr = addr;
    @(negedge clk);
    data = rd_data;
  endtask

  // Issues one command, plays the ALU (answers lat cycles after alu_en) and
  // optionally drives a host write in the alu_vld cycle. Returns at the first IDLE cycle.
  task automatic runAlu(input logic [18:0] c, input logic [WID-1:0] r, input logic [WID-1:0] rs,
                        input int lat, input logic hEn, input logic [2:0] hAddr,
                        input logic [WID-1:0] hData, output logic sawEn,
                        output logic [WID-1:0] aAtEn, output logic [WID-1:0] bAtEn,
                        output logic [6:0] ctlAtEn, output logic doneWb, output logic rdyWb);
    cmd = c; cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    sawEn = 1'b0; aAtEn = '0; bAtEn = '0; ctlAtEn = '0;
    for (int i = 0; i < 40; i++) begin
      if (alu_en === 1'b1) begin
        sawEn = 1'b1; aAtEn = alu_a; bAtEn = alu_b;
        ctlAtEn = {alu_opcode, alu_swapop, alu_swapvl, alu_c};
        break;
      end
      @(negedge clk);
    end
    for (int i = 0; i < lat; i++) @(negedge clk);
    alu_vld = 1'b1; alu_r = r; alu_rswap = rs;
    wr_en = hEn; wr_addr = hAddr; wr_data = hData;
    @(negedge clk);
    alu_vld = 1'b0; wr_en = 1'b0;
    doneWb = done; rdyWb = cmd_rdy;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++; if (cmd_rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_cmd_rdy got %b want 1", cmd_rdy); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    testsRun++; if ({done, err, alu_en} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_done_err_en got %b want 000", {done, err, alu_en}); end
    testsRun++; if ({alu_opcode, alu_swapop, alu_swapvl, alu_c} !== 7'd0) begin testsFailed++; $display("[TB] FAIL reset_alu_ctl got %b want 0", {alu_opcode, alu_swapop, alu_swapvl, alu_c}); end
    testsRun++; if (alu_a !== '0 || rd_data !== '0) begin testsFailed++; $display("[TB] FAIL reset_data got a=%h rd=%h want 0", alu_a, rd_data); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fa;
    logic sawEn, doneWb, rdyWb;
    logic [WID-1:0] a, b, rv;
    logic [6:0] ctl;
    hostWrite(3'd0, 256'd5);
    hostWrite(3'd1, 256'd7);
    enCount = 0; doneCount = 0;
    runAlu(mkCmd(4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 3'd0), 256'd12, '0, 2,
           1'b0, 3'd0, '0, sawEn, a, b, ctl, doneWb, rdyWb);
    testsRun++; if (sawEn !== 1'b1) begin testsFailed++; $display("[TB] FAIL fa_en_seen got %b want 1", sawEn); end
    testsRun++; if (a !== 256'd5 || b !== 256'd7) begin testsFailed++; $display("[TB] FAIL fa_operands got a=%0d b=%0d want 5 7", a, b); end
    testsRun++; if (ctl !== 7'd0) begin testsFailed++; $display("[TB] FAIL fa_ctl got %b want 0000000", ctl); end
    testsRun++; if (doneWb !== 1'b1 || rdyWb !== 1'b0) begin testsFailed++; $display("[TB] FAIL fa_wb_cycle got done=%b rdy=%b want 1 0", doneWb, rdyWb); end
    testsRun++; if (cmd_rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL fa_rdy_after got %b want 1", cmd_rdy); end
    repeat (2) @(negedge clk);
    testsRun++; if (enCount !== 1 || doneCount !== 1) begin testsFailed++; $display("[TB] FAIL fa_pulse_counts got en=%0d done=%0d want 1 1", enCount, doneCount); end
    testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL fa_err got %b want 0", err); end
    hostRead(3'd2, rv);
    testsRun++; if (rv !== 256'd12) begin testsFailed++; $display("[TB] FAIL fa_reg2 got %0d want 12", rv); end
  endtask

  task automatic test_illegal;
    enCount = 0; doneCount = 0;
    cmd = mkCmd(4'b0011, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd4, 3'd0);
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    testsRun++; if ({done, err, cmd_rdy, busy} !== 4'b1110) begin testsFailed++; $display("[TB] FAIL illegal_flags got done,err,rdy,busy=%b want 1110", {done, err, cmd_rdy, busy}); end
    repeat (4) @(negedge clk);
    testsRun++; if (enCount !== 0 || doneCount !== 1) begin testsFailed++; $display("[TB] FAIL illegal_counts got en=%0d done=%0d want 0 1", enCount, doneCount); end
    testsRun++; if (err !== 1'b1 || cmd_rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL illegal_sticky got err=%b rdy=%b want 1 1", err, cmd_rdy); end
  endtask

  task automatic test_swap;
    logic sawEn, doneWb, rdyWb;
    logic [WID-1:0] a, b, rv;
    logic [6:0] ctl;
    hostWrite(3'd3, VAL_A);
    hostWrite(3'd4, VAL_B);
    runAlu(mkCmd(4'b0001, 1'b1, 1'b1, 1'b1, 3'd3, 3'd4, 3'd3, 3'd4), VAL_B, VAL_A, 2,
           1'b0, 3'd0, '0, sawEn, a, b, ctl, doneWb, rdyWb);
    testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL swap_err_cleared got %b want 0", err); end
    testsRun++; if (ctl !== 7'b0001_1_1_1) begin testsFailed++; $display("[TB] FAIL swap_ctl got %b want 0001111", ctl); end
    testsRun++; if (a !== VAL_A || b !== VAL_B) begin testsFailed++; $display("[TB] FAIL swap_operands got a=%h b=%h", a, b); end
    hostRead(3'd3, rv);
    testsRun++; if (rv !== VAL_B) begin testsFailed++; $display("[TB] FAIL swap_reg3 got %h want %h", rv, VAL_B); end
    hostRead(3'd4, rv);
    testsRun++; if (rv !== VAL_A) begin testsFailed++; $display("[TB] FAIL swap_reg4 got %h want %h", rv, VAL_A); end
    runAlu(mkCmd(4'b0000, 1'b1, 1'b1, 1'b0, 3'd3, 3'd4, 3'd3, 3'd3), VAL_X1, VAL_X2, 1,
           1'b0, 3'd0, '0, sawEn, a, b, ctl, doneWb, rdyWb);
    hostRead(3'd3, rv);
    testsRun++; if (rv !== VAL_X2) begin testsFailed++; $display("[TB] FAIL swap_same_dst got %h want %h", rv, VAL_X2); end
    hostRead(3'd4, rv);
    testsRun++; if (rv !== VAL_A) begin testsFailed++; $display("[TB] FAIL swap_same_dst_reg4 got %h want %h", rv, VAL_A); end
  endtask

  task automatic test_status_hold;
    logic [WID-1:0] rv;
    enCount = 0;
    alu_status = 2'b01;
    cmd = mkCmd(4'b0010, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd5, 3'd0);
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    repeat (10) @(negedge clk);
    testsRun++; if (enCount !== 0 || alu_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_no_en got count=%0d en=%b want 0 0", enCount, alu_en); end
    testsRun++; if (busy !== 1'b1 || cmd_rdy !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_busy got busy=%b rdy=%b want 1 0", busy, cmd_rdy); end
    testsRun++; if (alu_opcode !== 4'b0010) begin testsFailed++; $display("[TB] FAIL hold_opcode got %b want 0010", alu_opcode); end
    alu_status = 2'b00;
    @(negedge clk);
    testsRun++; if (alu_en !== 1'b1) begin testsFailed++; $display("[TB] FAIL hold_en_release got %b want 1", alu_en); end
    @(negedge clk);
    testsRun++; if (alu_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_en_single got %b want 0", alu_en); end
    alu_vld = 1'b1; alu_r = VAL_S5;
    @(negedge clk);
    alu_vld = 1'b0;
    testsRun++; if (done !== 1'b1) begin testsFailed++; $display("[TB] FAIL hold_done got %b want 1", done); end
    @(negedge clk);
    testsRun++; if (enCount !== 1) begin testsFailed++; $display("[TB] FAIL hold_en_count got %0d want 1", enCount); end
    hostRead(3'd5, rv);
    testsRun++; if (rv !== VAL_S5) begin testsFailed++; $display("[TB] FAIL hold_reg5 got %h want %h", rv, VAL_S5); end
  endtask

  task automatic test_collision;
    logic sawEn, doneWb, rdyWb;
    logic [WID-1:0] a, b, rv;
    logic [6:0] ctl;
    runAlu(mkCmd(4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 3'd0), VAL_W1, '0, 1,
           1'b1, 3'd2, VAL_JK, sawEn, a, b, ctl, doneWb, rdyWb);
    hostRead(3'd2, rv);
    testsRun++; if (rv !== VAL_W1) begin testsFailed++; $display("[TB] FAIL coll_wb_wins got %h want %h", rv, VAL_W1); end
    runAlu(mkCmd(4'b0001, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 3'd3), VAL_W2, VAL_W3, 1,
           1'b1, 3'd5, VAL_H5, sawEn, a, b, ctl, doneWb, rdyWb);
    hostRead(3'd5, rv);
    testsRun++; if (rv !== VAL_H5) begin testsFailed++; $display("[TB] FAIL coll_host_reg5 got %h want %h", rv, VAL_H5); end
    hostRead(3'd2, rv);
    testsRun++; if (rv !== VAL_W2) begin testsFailed++; $display("[TB] FAIL coll_reg2 got %h want %h", rv, VAL_W2); end
    hostRead(3'd3, rv);
    testsRun++; if (rv !== VAL_W3) begin testsFailed++; $display("[TB] FAIL coll_reg3 got %h want %h", rv, VAL_W3); end
  endtask

  task automatic test_reset_mid;
    logic [WID-1:0] rv;
    logic sawEn;
    hostWrite(3'd6, VAL_6);
    doneCount = 0;
    cmd = mkCmd(4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd6, 3'd0);
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    sawEn = 1'b0;
    for (int i = 0; i < 40 && !sawEn; i++) begin
      if (alu_en === 1'b1) sawEn = 1'b1;
      else @(negedge clk);
    end
    testsRun++; if (sawEn !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_en_seen got %b want 1", sawEn); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    testsRun++; if ({cmd_rdy, busy, done, alu_en} !== 4'b1000) begin testsFailed++; $display("[TB] FAIL rstmid_idle got rdy,busy,done,en=%b want 1000", {cmd_rdy, busy, done, alu_en}); end
    @(negedge clk);
    alu_vld = 1'b1; alu_r = VAL_JK;
    @(negedge clk);
    alu_vld = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++; if (doneCount !== 0 || cmd_rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_no_done got done=%0d rdy=%b want 0 1", doneCount, cmd_rdy); end
    hostRead(3'd6, rv);
    testsRun++; if (rv !== '0) begin testsFailed++; $display("[TB] FAIL rstmid_reg6 got %h want 0", rv); end
  endtask

`ifdef ALU_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    logic [WID-1:0] rv;
    logic sawEn, doneEarly;
    hostWrite(3'd7, VAL_7);
    cmd = mkCmd(4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd7, 3'd0);
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    sawEn = 1'b0;
    for (int i = 0; i < 40 && !sawEn; i++) begin
      if (alu_en === 1'b1) sawEn = 1'b1;
      else @(negedge clk);
    end
    testsRun++; if (sawEn !== 1'b1) begin testsFailed++; $display("[TB] FAIL tout_en_seen got %b want 1", sawEn); end
    doneEarly = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done !== 1'b0) doneEarly = 1'b1;
    end
    testsRun++; if (doneEarly !== 1'b0) begin testsFailed++; $display("[TB] FAIL tout_early_done got %b want 0", doneEarly); end
    @(negedge clk);
    testsRun++; if ({done, err, cmd_rdy} !== 3'b111) begin testsFailed++; $display("[TB] FAIL tout_flags got done,err,rdy=%b want 111", {done, err, cmd_rdy}); end
    hostRead(3'd7, rv);
    testsRun++; if (rv !== VAL_7) begin testsFailed++; $display("[TB] FAIL tout_reg7 got %h want %h", rv, VAL_7); end
  endtask
`endif

  initial begin
    testsRun = 0; testsFailed = 0; enCount = 0; doneCount = 0;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    cmd_vld = 1'b0; cmd = '0; alu_r = '0; alu_rswap = '0; alu_vld = 1'b0; alu_status = 2'b00;
    test_reset();
    test_fa();
    test_illegal();
    test_swap();
    test_status_hold();
    test_collision();
    test_reset_mid();
`ifdef ALU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired after 200000 time units");
    $fatal(1, "[TB] watchdog");
  end

endmodule
